// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter sharing one async FIFO write side among
// NREQ valid/ready producers. Grants one producer at a time for a burst of
// up to MAX_BURST beats, drives winc/wdata and never writes while wfull.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wfull,
  output logic                     winc,
  output logic [WIDTH-1:0]         wdata,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]     state;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] last_owner;
  logic [IDW-1:0] next_owner;
  logic [CW-1:0]  beat_cnt;
  logic           owner_valid;
  logic [WIDTH-1:0] owner_data;

  // Round-robin pick: first valid requester searching upward from last_owner+1
  always_comb begin
    logic           hit;
    logic [IDW-1:0] idx;
    next_owner = '0;
    hit        = 1'b0;
    idx        = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IDW'((32'(last_owner) + k) % NREQ);
      if (!hit && req_valid[idx]) begin
        next_owner = idx;
        hit        = 1'b1;
      end
    end
  end

  // Owner's valid and data, muxed by index
  always_comb begin
    owner_valid = req_valid[owner];
    owner_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner == IDW'(i)) owner_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Grant FSM: arbitrate in IDLE, count beats and release in GRANT
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IDW'(NREQ - 1);
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            owner    <= next_owner;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (winc) begin
            if (beat_cnt == CW'(MAX_BURST - 1)) begin
              last_owner <= owner;
              beat_cnt   <= '0;
              state      <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end else if (!owner_valid) begin
            last_owner <= owner;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write-side outputs; all zero outside GRANT so reset drops them at once
  always_comb begin
    req_ready = '0;
    winc      = 1'b0;
    wdata     = '0;
    busy      = 1'b0;
    if (state == GRANT) begin
      busy             = 1'b1;
      req_ready[owner] = ~wfull;
      winc             = owner_valid & ~wfull;
      wdata            = owner_data;
    end
  end

  assign grant_id = owner;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized checks for fifo_wr_arbiter (WIDTH=8, NREQ=4, MAX_BURST=4).
module tb_fifo_wr_arbiter;

  localparam int W     = 8;
  localparam int N     = 4;
  localparam int MB    = 4;
  localparam int BOUND = (N - 1) * (MB + 1) + 1;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           wfull;
  logic           winc;
  logic [W-1:0]   wdata;
  logic [1:0]     grant_id;
  logic           busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .WIDTH(W),
    .NREQ(N),
    .MAX_BURST(MB)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .wfull(wfull),
    .winc(winc),
    .wdata(wdata),
    .grant_id(grant_id),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [W-1:0] d);
    req_valid[i]       = v;
    req_data[i*W +: W] = d;
  endtask

  task automatic exp_idle(input string tag, input logic [1:0] gid);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_winc"},  32'(winc), 0);
    chk({tag, "_ready"}, 32'(req_ready), 0);
    chk({tag, "_wdata"}, 32'(wdata), 0);
    chk({tag, "_gid"},   32'(grant_id), 32'(gid));
  endtask

  task automatic exp_beat(input string tag, input int id, input logic [W-1:0] d);
    chk({tag, "_winc"},  32'(winc), 1);
    chk({tag, "_wdata"}, 32'(wdata), 32'(d));
    chk({tag, "_ready"}, 32'(req_ready), 32'(1 << id));
    chk({tag, "_gid"},   32'(grant_id), 32'(id));
    chk({tag, "_busy"},  32'(busy), 1);
  endtask

  // n beats from requester id with data start, start+1, ...; wfull held low
  task automatic burst(input string tag, input int id, input logic [W-1:0] start, input int n);
    for (int k = 0; k < n; k++) begin
      step();
      wfull = 1'b0;
      set_req(id, 1'b1, start + W'(k));
      #1;
      exp_beat(tag, id, start + W'(k));
    end
  endtask

  int           seq [N];
  int           wait_cnt [N];
  logic [N-1:0] acc;
  logic [N-1:0] acc_prev;
  logic [W-1:0] base [N];
  logic [W-1:0] cnt [N];
  int           order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rstn      = 1'b0;
    req_valid = '0;
    req_data  = '0;
    wfull     = 1'b0;

    // Reset state
    step();
    step();
    exp_idle("rst", 2'd0);

    // Single requester: two 4-beat bursts separated by one IDLE cycle
    rstn = 1'b1;
    set_req(0, 1'b1, 8'h10);
    #1;
    exp_idle("t1_arb", 2'd0);
    burst("t1_b0", 0, 8'h10, 4);
    step();
    set_req(0, 1'b1, 8'h14);
    #1;
    exp_idle("t1_gap", 2'd0);
    burst("t1_b1", 0, 8'h14, 4);
    step();
    set_req(0, 1'b0, 8'h00);
    #1;
    exp_idle("t1_end", 2'd0);

    // All four valid: grants 0,1,2,3,0 after a fresh reset
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    for (int i = 0; i < N; i++) begin
      base[i] = W'(8'h20 + 8'h10 * i);
      cnt[i]  = '0;
      set_req(i, 1'b1, base[i]);
    end
    #1;
    exp_idle("t2_arb", 2'd0);
    for (int g = 0; g < 5; g++) begin
      burst("t2_burst", order[g], base[order[g]] + cnt[order[g]], 4);
      cnt[order[g]] = cnt[order[g]] + 8'd4;
      step();
      if (g == 4) req_valid = '0;
      else set_req(order[g], 1'b1, base[order[g]] + cnt[order[g]]);
      #1;
      exp_idle("t2_gap", 2'(order[g]));
    end

    // wfull backpressure on requester 1 after two beats
    set_req(1, 1'b1, 8'h40);
    #1;
    exp_idle("t3_arb", 2'd0);
    burst("t3_pre", 1, 8'h40, 2);
    for (int s = 0; s < 5; s++) begin
      step();
      wfull = 1'b1;
      set_req(1, 1'b1, 8'h42);
      #1;
      chk("t3_stall_winc",  32'(winc), 0);
      chk("t3_stall_ready", 32'(req_ready), 0);
      chk("t3_stall_gid",   32'(grant_id), 1);
      chk("t3_stall_busy",  32'(busy), 1);
      chk("t3_stall_cnt",   32'(dut.beat_cnt), 2);
    end
    burst("t3_post", 1, 8'h42, 2);
    step();
    set_req(1, 1'b0, 8'h00);
    #1;
    exp_idle("t3_end", 2'd1);

    // Early release by requester 2 with requester 3 waiting
    set_req(2, 1'b1, 8'h50);
    set_req(3, 1'b1, 8'h60);
    #1;
    exp_idle("t4_arb", 2'd1);
    burst("t4_r2", 2, 8'h50, 1);
    step();
    set_req(2, 1'b0, 8'h00);
    #1;
    chk("t4_rel_winc",  32'(winc), 0);
    chk("t4_rel_busy",  32'(busy), 1);
    chk("t4_rel_gid",   32'(grant_id), 2);
    chk("t4_rel_ready", 32'(req_ready), 32'h4);
    step();
    #1;
    exp_idle("t4_gap", 2'd2);
    burst("t4_r3", 3, 8'h60, 4);
    step();
    set_req(3, 1'b0, 8'h00);
    #1;
    exp_idle("t4_end", 2'd3);

    // Reset during beat 3 of requester 0
    set_req(0, 1'b1, 8'h70);
    #1;
    exp_idle("t5_arb", 2'd3);
    burst("t5_pre", 0, 8'h70, 3);
    rstn = 1'b0;
    #1;
    exp_idle("t5_rst", 2'd0);
    set_req(1, 1'b1, 8'h80);
    step();
    step();
    #1;
    exp_idle("t5_hold", 2'd0);
    rstn = 1'b1;
    #1;
    exp_idle("t5_rel", 2'd0);
    step();
    #1;
    exp_beat("t5_regrant", 0, 8'h72);
    rstn      = 1'b0;
    req_valid = '0;
    #1;
    rstn = 1'b1;

    // Randomized traffic with random wfull
    acc_prev = '0;
    for (int i = 0; i < N; i++) begin
      seq[i]      = 0;
      wait_cnt[i] = 0;
    end
    for (int c = 0; c < 2000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (acc_prev[i]) seq[i]++;
        if (acc_prev[i] || !req_valid[i]) begin
          set_req(i, ($urandom_range(0, 2) != 0), W'({2'(i), 6'(seq[i])}));
          wait_cnt[i] = 0;
        end
      end
      wfull = ($urandom_range(0, 3) == 0);
      #1;
      acc = req_ready & req_valid;
      chk("rnd_ready_onehot", 32'($countones(req_ready) <= 1), 1);
      chk("rnd_winc_full",    32'(winc & wfull), 0);
      chk("rnd_winc_acc",     32'(winc), 32'(|acc));
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          chk("rnd_wdata", 32'(wdata), 32'({2'(i), 6'(seq[i])}));
        end else if (req_valid[i] && !wfull) begin
          wait_cnt[i]++;
          chk("rnd_wait_bound", 32'(wait_cnt[i] <= BOUND), 1);
        end
      end
      acc_prev = acc;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of one `asyn_fifo` instance among `NREQ` producers in the write-clock domain. Each producer presents a valid/ready stream. The arbiter grants one producer at a time for a bounded burst and drives the FIFO `winc`/`wdata` pair, honouring `wfull`. It sits directly in front of the FIFO write port and runs on the FIFO write clock.

## Interface
- `WIDTH`, 8, data word width; must match the FIFO `WIDTH`.
- `NREQ`, 4, number of requesters; range 2..8.
- `MAX_BURST`, 4, maximum beats per grant before forced rotation; range 1..16.
- `clk`  in  1  write-side clock, same net as the FIFO `wclk`.
- `rstn`  in  1  asynchronous active-low reset.
- `req_valid`  in  NREQ  per-requester data valid.
- `req_data`  in  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero.
- `wfull`  in  1  FIFO full flag, `wclk` domain.
- `winc`  out  1  FIFO write enable.
- `wdata`  out  WIDTH  FIFO write data.
- `grant_id`  out  $clog2(NREQ)  index of the current owner.
- `busy`  out  1  high while a grant is held.

## Operation
- State machine with two states: IDLE and GRANT. Registers: `state`, `owner`, `last_owner`, `beat_cnt` ($clog2(MAX_BURST+1) bits).
- **IDLE**
  - If any `req_valid` is high, select the first set bit searching from `last_owner+1` upward, modulo NREQ.
  - Load `owner`, clear `beat_cnt`, and go to GRANT on the next edge.
  - No beats are accepted in IDLE.
- **GRANT, combinational outputs**
  - `req_ready[owner] = ~wfull`.
  - `winc = req_valid[owner] & ~wfull`.
  - `wdata = req_data[owner]`.
  - A beat transfers when `winc` is high.
- **GRANT, on a transferred beat**
  - `beat_cnt` increments.
  - If `beat_cnt == MAX_BURST-1`, the burst is complete: `last_owner <= owner`, go to IDLE.
- **GRANT, release without a beat**
  - If `req_valid[owner]` is low, release: `last_owner <= owner`, go to IDLE. Partial bursts are allowed.
- **GRANT, stall**
  - If `wfull` is high, hold state, `owner`, and `beat_cnt`.
  - No timeout; `req_valid[owner]` held high keeps the grant.
- **Requester rules**
  - `req_valid` and `req_data` must stay stable until accepted.
  - Valid from non-owners is ignored and never lost; it is served in a later rotation.
- **Output values outside GRANT**
  - In IDLE, `req_ready = 0`, `winc = 0`, `wdata = 0`, `busy = 0`.
  - `grant_id` shows `owner` in both states; in IDLE it holds the last owner.
- **Reset**
  - `state = IDLE`, `owner = 0`, `last_owner = NREQ-1` (first priority goes to requester 0), `beat_cnt = 0`.
  - Outputs: `winc = 0`, `req_ready = 0`, `wdata = 0`, `busy = 0`, `grant_id = 0`.
  - Assertion mid-burst drops the grant immediately: no `winc` during reset, and the in-flight beat is not written.

## Timing
- Arbitration latency is 1 cycle: valid is seen in IDLE, and the first beat can transfer on the next cycle.
- Throughput:
  - Up to MAX_BURST beats per MAX_BURST+1 cycles for a single busy requester.
  - Each grant boundary costs one IDLE cycle.
- `winc` goes high in the same cycle `wfull` deasserts. It is never high while `wfull` is high, so there is no overflow beat.
- `wfull` rising in the same cycle as a handshake blocks that beat: `winc = 0`, and it is not counted.
- Simultaneous burst completion and a new request from the same owner: the owner goes to the back of the rotation. It is regranted only if no other requester is valid in the IDLE cycle.
- Burst wrap: `beat_cnt` never exceeds MAX_BURST-1; it clears on each grant.
- Round-robin wrap: the search from `last_owner = NREQ-1` starts at index 0.

## Test plan
- **Reset, then single requester:** release reset, requester 0 holds valid with data 0x10..0x17.
  - IDLE cycle, then 0x10–0x13 written on 4 consecutive cycles.
  - Then one IDLE cycle, regrant to requester 0, 0x14–0x17 written.
- **All four requesters valid together:** grants in order 0, 1, 2, 3, 0.
  - Each burst is 4 beats, with one IDLE cycle between bursts.
  - FIFO contents are ordered by burst.
- **wfull backpressure:** requester 1 mid-burst after 2 beats, `wfull` high for 5 cycles.
  - `winc` and `req_ready` stay low, `beat_cnt` holds at 2, `grant_id` stays 1.
  - After release, exactly 2 more beats complete the burst.
- **Early release:** requester 2 drops valid after 1 beat while requester 3 is waiting.
  - IDLE, then grant to 3. No beat from 2 is lost or duplicated.
- **Reset mid-burst:** assert `rstn` low during beat 3 of requester 0.
  - `winc` drops immediately, all outputs take their reset values.
  - After release, the next grant goes to requester 0.
- **Scoreboard over 2000 random cycles:** random valid patterns and random `wfull`.
  - Every accepted beat appears exactly once at `winc`/`wdata`.
  - `req_ready` is never multi-hot, and `winc & wfull` is never true.
  - No requester waits more than `(NREQ-1)*(MAX_BURST+1)+1` cycles of non-full time for a grant.
